// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and schedule helper functions.
// Imported by the message scheduler and, later, by the round pipeline.
package sha256_pkg;

  localparam int unsigned ROUNDS = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DONE
  } state_e;

  localparam logic [31:0] K [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotate right by a constant amount; the doubled word keeps widths exact.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    logic [63:0] xx;
    xx = {x, x} >> n;
    return xx[31:0];
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup, K[idx].
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [31:0] k
);

  assign k = K[idx];

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: loads 16 words, expands W[0..63] in a 16-word
// sliding window and drives one (W, K) pair plus control strobes per round slot.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int unsigned ROUND_CYCLES = 4,
  parameter int unsigned ROUNDS       = sha256_pkg::ROUNDS
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        blk_valid_i,
  output logic        blk_ready_o,
  input  logic [31:0] blk_word_i,
  input  logic        msg_first_i,
  output logic [31:0] w_o,
  output logic [31:0] k_o,
  output logic        clr_o,
  output logic        update_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned     CYCLES   = ROUNDS * ROUND_CYCLES;
  localparam int unsigned     CYC_W    = $clog2(CYCLES);
  localparam int unsigned     RND_W    = $clog2(ROUNDS);
  localparam logic [CYC_W-1:0] PH_MASK  = CYC_W'(ROUND_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_PEN  = CYC_W'(CYCLES - 2);

  state_e           state_q;
  logic [3:0]       wcnt_q;
  logic [CYC_W-1:0] cyc_q;
  logic             first_q;
  logic [31:0]      win_q [16];
  logic [31:0]      w_q;
  logic [31:0]      k_q;
  logic             clr_q;
  logic             update_q;
  logic             busy_q;
  logic             done_q;

  logic             xfer;
  logic [RND_W-1:0] rnd;
  logic             slot_end;
  logic             run_shift;
  logic             shift_en;
  logic [31:0]      shift_in;
  logic [31:0]      w_next;
  logic [5:0]       rom_idx;
  logic [31:0]      rom_k;

  assign blk_ready_o = (state_q == IDLE) || (state_q == LOAD);
  assign xfer        = blk_valid_i && blk_ready_o;

  // Round index is the upper field of the cycle counter; the phase is the rest.
  assign rnd       = cyc_q[CYC_W-1 -: RND_W];
  assign slot_end  = (cyc_q & PH_MASK) == PH_MASK;
  assign run_shift = (state_q == RUN) && slot_end && (cyc_q != CYC_LAST);

  // W[t+16] from the window holding W[t..t+15].
  assign w_next = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    shift_en = 1'b0;
    shift_in = blk_word_i;
    rom_idx  = '0;
    if (state_q == RUN) begin
      shift_en = run_shift;
      shift_in = w_next;
      rom_idx  = 6'(rnd + 1'b1);
    end else if (xfer) begin
      shift_en = 1'b1;
    end
  end

  sha256_k_rom u_k_rom (
    .idx (rom_idx),
    .k   (rom_k)
  );

  // NOTE: the window is a handful of flops, so it is reset like any other
  // state; a large RAM-style array would normally be left unreset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
      win_q[15] <= shift_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      cyc_q    <= '0;
      first_q  <= 1'b0;
      w_q      <= '0;
      k_q      <= '0;
      clr_q    <= 1'b0;
      update_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      clr_q    <= 1'b0;
      update_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            first_q <= msg_first_i;
            wcnt_q  <= 4'd1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (xfer) begin
            if (wcnt_q == 4'd15) begin
              wcnt_q  <= '0;
              clr_q   <= first_q;
              state_q <= START;
            end else begin
              wcnt_q <= wcnt_q + 4'd1;
            end
          end
        end
        START: begin
          cyc_q   <= '0;
          busy_q  <= 1'b1;
          w_q     <= win_q[0];
          k_q     <= rom_k;
          state_q <= RUN;
        end
        RUN: begin
          if (cyc_q == CYC_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cyc_q    <= cyc_q + 1'b1;
            update_q <= (cyc_q == CYC_PEN);
            if (slot_end) begin
              w_q <= win_q[1];
              k_q <= rom_k;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign w_o      = w_q;
  assign k_o      = k_q;
  assign clr_o    = clr_q;
  assign update_o = update_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched with a behavioural SHA-256 round model
// consuming w_o/k_o/clr_o/update_o to produce the final digest.
module tb_sha256_msg_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        blk_valid_i = 1'b0;
  logic        blk_ready_o;
  logic [31:0] blk_word_i = '0;
  logic        msg_first_i = 1'b0;
  logic [31:0] w_o;
  logic [31:0] k_o;
  logic        clr_o;
  logic        update_o;
  logic        busy_o;
  logic        done_o;

  always #5 clk_i = ~clk_i;

  sha256_msg_sched #(.ROUND_CYCLES(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .blk_valid_i (blk_valid_i),
    .blk_ready_o (blk_ready_o),
    .blk_word_i  (blk_word_i),
    .msg_first_i (msg_first_i),
    .w_o         (w_o),
    .k_o         (k_o),
    .clr_o       (clr_o),
    .update_o    (update_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  typedef struct {
    int          t;
    bit          chk_w;
    logic [31:0] w;
    logic [31:0] k;
  } vec_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  int          n_cmp = 0;
  int          n_err = 0;
  vec_t        vecs [8];
  logic [31:0] blocks  [3][16];
  logic [31:0] digests [2][8];

  // Monitor / round-model state.
  int          cyc_n = 0;
  int          run_start = 0;
  int          mon_rel = 0;
  int          clr_at = 0, upd_at = 0, done_at = 0, done_abs = 0;
  int          clr_cnt = 0, upd_cnt = 0, done_cnt = 0;
  int          stable_err = 0, ready_err = 0;
  int          acc_gap = 0;
  logic [31:0] w_rec [64];
  logic [31:0] k_rec [64];
  logic [31:0] k_done = '0;
  logic        busy_prev = 1'b0, ready_prev = 1'b0;
  logic [31:0] hh [8];
  logic [31:0] wv [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic do_round(input logic [31:0] w, input logic [31:0] k);
    logic [31:0] t1, t2, ch, mj;
    ch = (wv[4] & wv[5]) ^ (~wv[4] & wv[6]);
    mj = (wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]);
    t1 = wv[7] + (rr(wv[4], 6) ^ rr(wv[4], 11) ^ rr(wv[4], 25)) + ch + k + w;
    t2 = (rr(wv[0], 2) ^ rr(wv[0], 13) ^ rr(wv[0], 22)) + mj;
    wv[7] = wv[6]; wv[6] = wv[5]; wv[5] = wv[4]; wv[4] = wv[3] + t1;
    wv[3] = wv[2]; wv[2] = wv[1]; wv[1] = wv[0]; wv[0] = t1 + t2;
  endtask

  // Round-pipeline stand-in plus protocol monitor, sampling on the falling edge.
  always @(negedge clk_i) begin
    cyc_n++;
    if (clr_o) begin
      clr_cnt++;
      clr_at = cyc_n;
      for (int i = 0; i < 8; i++) begin hh[i] = IV[i]; wv[i] = IV[i]; end
    end
    if (busy_o && !busy_prev) begin
      run_start = cyc_n;
      if (ready_prev) ready_err++;
    end
    if (busy_o) begin
      mon_rel = cyc_n - run_start;
      if (mon_rel / 4 < 64) begin
        if (mon_rel % 4 == 0) begin
          w_rec[mon_rel/4] = w_o;
          k_rec[mon_rel/4] = k_o;
          do_round(w_o, k_o);
        end else if (w_o !== w_rec[mon_rel/4] || k_o !== k_rec[mon_rel/4]) begin
          stable_err++;
        end
      end
    end
    if ((busy_o || done_o || clr_o) && blk_ready_o) ready_err++;
    if (update_o) begin
      upd_cnt++;
      upd_at = cyc_n - run_start;
      for (int i = 0; i < 8; i++) begin hh[i] = hh[i] + wv[i]; wv[i] = hh[i]; end
    end
    if (done_o) begin
      done_cnt++;
      done_at  = cyc_n - run_start;
      done_abs = cyc_n;
      k_done   = k_o;
    end
    busy_prev  = busy_o;
    ready_prev = blk_ready_o;
  end

  task automatic reset_counts();
    clr_cnt = 0; upd_cnt = 0; done_cnt = 0;
    stable_err = 0; ready_err = 0;
  endtask

  task automatic send_block(input int id, input logic first, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      int b;
      if (gaps && $urandom_range(1, 0) == 1) begin
        blk_valid_i = 1'b0;
        repeat ($urandom_range(2, 1)) @(posedge clk_i);
        #1;
      end
      blk_valid_i = 1'b1;
      blk_word_i  = blocks[id][i];
      msg_first_i = (i == 0) ? first : ~first;
      b = 0;
      while (!blk_ready_o && b < 2000) begin
        @(posedge clk_i); #1;
        b++;
      end
      if (b >= 2000) timeout_fail("ready_wait");
      @(posedge clk_i);
      if (i == 0) acc_gap = cyc_n - done_abs;
      #1;
    end
    blk_valid_i = 1'b0;
    msg_first_i = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int b;
    b = 0;
    while (done_cnt < n && b < 3000) begin
      @(posedge clk_i); #1;
      b++;
    end
    if (done_cnt < n) timeout_fail("done_wait");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w"},      w_o, 32'h0);
    check({tag, "_k"},      k_o, 32'h0);
    check({tag, "_clr"},    32'(clr_o), 32'h0);
    check({tag, "_update"}, 32'(update_o), 32'h0);
    check({tag, "_busy"},   32'(busy_o), 32'h0);
    check({tag, "_done"},   32'(done_o), 32'h0);
    check({tag, "_ready"},  32'(blk_ready_o), 32'h1);
  endtask

  task automatic check_sched(input int id);
    logic [31:0] mw [64];
    for (int t = 0; t < 64; t++) begin
      if (t < 16) mw[t] = blocks[id][t];
      else mw[t] = ssig1(mw[t-2]) + mw[t-7] + ssig0(mw[t-15]) + mw[t-16];
      check($sformatf("sched%0d_w%0d", id, t), w_rec[t], mw[t]);
    end
  endtask

  task automatic check_digest(input int d, input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_H%0d", tag, i), hh[i], digests[d][i]);
  endtask

  task automatic check_timing(input string tag);
    check({tag, "_upd_at"},  32'(upd_at), 32'd255);
    check({tag, "_done_at"}, 32'(done_at), 32'd256);
    check({tag, "_stable"},  32'(stable_err), 32'd0);
    check({tag, "_ready0"},  32'(ready_err), 32'd0);
  endtask

  initial begin
    // "abc" padded block, and the two-block 448-bit message.
    for (int i = 0; i < 16; i++) begin
      blocks[0][i] = '0;
      blocks[2][i] = '0;
    end
    blocks[0][0]  = 32'h61626380;
    blocks[0][15] = 32'h00000018;
    blocks[1] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                  32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                  32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                  32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    blocks[2][15] = 32'h000001c0;
    digests[0] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                   32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    digests[1] = '{32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                   32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

    vecs[0] = '{t: 0,  chk_w: 1'b1, w: 32'h61626380, k: 32'h428a2f98};
    vecs[1] = '{t: 1,  chk_w: 1'b1, w: 32'h00000000, k: 32'h71374491};
    vecs[2] = '{t: 14, chk_w: 1'b1, w: 32'h00000000, k: 32'h9bdc06a7};
    vecs[3] = '{t: 15, chk_w: 1'b1, w: 32'h00000018, k: 32'hc19bf174};
    vecs[4] = '{t: 16, chk_w: 1'b1, w: 32'h61626380, k: 32'he49b69c1};
    vecs[5] = '{t: 17, chk_w: 1'b1, w: 32'h000f0000, k: 32'hefbe4786};
    vecs[6] = '{t: 18, chk_w: 1'b1, w: 32'h7da86405, k: 32'h0fc19dc6};
    vecs[7] = '{t: 63, chk_w: 1'b0, w: 32'h00000000, k: 32'hc67178f2};

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // "abc", no gaps.
    reset_counts();
    send_block(0, 1'b1, 1'b0);
    wait_done(1);
    check("abc_clr_cnt", 32'(clr_cnt), 32'd1);
    check("abc_clr_in_start", 32'(run_start - clr_at), 32'd1);
    check("abc_upd_cnt", 32'(upd_cnt), 32'd1);
    check_timing("abc");
    check("abc_k_done", k_done, 32'hc67178f2);
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].chk_w)
        check($sformatf("vec_w%0d", vecs[v].t), w_rec[vecs[v].t], vecs[v].w);
      check($sformatf("vec_k%0d", vecs[v].t), k_rec[vecs[v].t], vecs[v].k);
    end
    check_sched(0);
    check_digest(0, "abc");

    // "abc" with random valid gaps during LOAD.
    reset_counts();
    send_block(0, 1'b1, 1'b1);
    wait_done(1);
    check("gap_clr_cnt", 32'(clr_cnt), 32'd1);
    check("gap_clr_in_start", 32'(run_start - clr_at), 32'd1);
    check_timing("gap");
    check_sched(0);
    check_digest(0, "gap");

    // Two-block message; block 2 word 0 held valid throughout block 1's RUN.
    reset_counts();
    send_block(1, 1'b1, 1'b0);
    send_block(2, 1'b0, 1'b0);
    check("two_acc_after_done", 32'(acc_gap), 32'd1);
    wait_done(2);
    check("two_clr_cnt", 32'(clr_cnt), 32'd1);
    check("two_upd_cnt", 32'(upd_cnt), 32'd2);
    check("two_stable", 32'(stable_err), 32'd0);
    check("two_ready0", 32'(ready_err), 32'd0);
    check_sched(2);
    check_digest(1, "two");

    // Asynchronous reset at RUN cycle 100, then a fresh "abc" block.
    reset_counts();
    send_block(0, 1'b1, 1'b0);
    begin
      int b;
      b = 0;
      while (!busy_o && b < 50) begin
        @(posedge clk_i); #1;
        b++;
      end
      if (!busy_o) timeout_fail("run_entry_wait");
    end
    repeat (100) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midrun");
    repeat (5) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    check("midrun_no_update", 32'(upd_cnt), 32'd0);
    check("midrun_no_done", 32'(done_cnt), 32'd0);
    reset_counts();
    send_block(0, 1'b1, 1'b0);
    wait_done(1);
    check("after_rst_upd_cnt", 32'(upd_cnt), 32'd1);
    check_timing("after_rst");
    check_digest(0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
